run_length_serializer: RTL and testbench

//  Transmit end of the run-length bit link. Accepts run-length symbols L (0..MAX_RUN) over a

---
 rtl/rle_pkg.sv | 14 +
 rtl/rle_sym_fifo.sv | 50 +++++
 rtl/run_length_serializer.sv | 102 ++++++++++
 tb/tb_run_length_serializer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rle_pkg.sv
// Shared definitions for the run-length link: symbol width, largest legal run and
// the serializer state encoding.
package rle_pkg;

  localparam int RLE_CNT_W   = 3;
  localparam int RLE_MAX_RUN = 4;

  typedef enum logic [1:0] {
    IDLE,
    ONES,
    ZERO
  } ser_state_t;

endpackage

// File: rtl/rle_sym_fifo.sv
// Small synchronous symbol FIFO. The head entry is readable combinationally whenever
// the FIFO is not empty. Pushes into a full FIFO and pops from an empty one are ignored.
module rle_sym_fifo
  import rle_pkg::*;
#(
  parameter int WIDTH = RLE_CNT_W,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr_reg;
  logic [PW-1:0]    rd_ptr_reg;
  logic             do_push;
  logic             do_pop;

  // The extra pointer MSB separates "wrapped once" (full) from "equal" (empty).
  assign empty   = (wr_ptr_reg == rd_ptr_reg);
  assign full    = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                   (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (do_pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg[AW-1:0]] <= din;
  end

endmodule

// File: rtl/run_length_serializer.sv
// Transmit side of the run-length link: buffers symbols and sends each L as L ones
// followed by a single zero terminator, back-to-back with no idle bubble.
module run_length_serializer
  import rle_pkg::*;
#(
  parameter int CNT_W      = RLE_CNT_W,
  parameter int MAX_RUN    = RLE_MAX_RUN,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CNT_W-1:0] in_len,
  output logic             a,
  output logic             a_valid,
  output logic             busy,
  output logic             len_err
);

  localparam logic [CNT_W-1:0] MAX_L = CNT_W'(MAX_RUN);

  ser_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             a_reg, a_valid_reg, len_err_reg;

  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_pop;
  logic [CNT_W-1:0] fifo_head;
  logic             accept;
  logic             illegal;

  assign in_ready = !fifo_full;
  assign accept   = in_valid && in_ready;
  assign illegal  = (in_len > MAX_L);

  // Over-long symbols are swallowed here and never reach the buffer.
  rle_sym_fifo #(
    .WIDTH (CNT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept && !illegal),
    .din   (in_len),
    .pop   (fifo_pop),
    .head  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      IDLE, ZERO: begin
        // A terminator cycle may load the next symbol directly, keeping the line gapless.
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          if (fifo_head != '0) begin
            state_next = ONES;
            cnt_next   = fifo_head - CNT_W'(1);
          end else begin
            state_next = ZERO;
            cnt_next   = '0;
          end
        end else begin
          state_next = IDLE;
        end
      end
      ONES: begin
        if (cnt_reg == '0) state_next = ZERO;
        else               cnt_next   = cnt_reg - CNT_W'(1);
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      cnt_reg     <= '0;
      a_reg       <= 1'b0;
      a_valid_reg <= 1'b0;
      len_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      cnt_reg     <= cnt_next;
      a_reg       <= (state_next == ONES);
      a_valid_reg <= (state_next != IDLE);
      len_err_reg <= accept && illegal;
    end
  end

  assign a       = a_reg;
  assign a_valid = a_valid_reg;
  assign len_err = len_err_reg;
  assign busy    = (state_reg != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_run_length_serializer.sv
// Directed bench for run_length_serializer: a model receiver and bit-pattern scoreboard
// watch the line while directed symbol sequences are pushed through.
module tb_run_length_serializer;
  import rle_pkg::*;

  localparam int MAXR = RLE_MAX_RUN;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_len;
  logic       a;
  logic       a_valid;
  logic       busy;
  logic       len_err;

  always #5 clk = ~clk;

  run_length_serializer dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_len   (in_len),
    .a        (a),
    .a_valid  (a_valid),
    .busy     (busy),
    .len_err  (len_err)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  int exp_bits[$];
  int exp_len[$];
  int rx_q        = 0;
  int err_seen    = 0;
  int illegal_cnt = 0;
  int vcount      = 0;
  int vrise       = 0;
  bit prev_valid  = 1'b0;
  bit mon_en      = 1'b0;

  // Model receiver: counts ones, checks the count at each terminator.
  always @(negedge clk) begin
    if (mon_en) begin
      if (a_valid) begin
        vcount++;
        if (!prev_valid) vrise++;
        check("bit_expected", exp_bits.size() > 0, 1);
        if (exp_bits.size() > 0) check("bit", a, exp_bits.pop_front());
        if (a) rx_q++;
        else begin
          check("sym_expected", exp_len.size() > 0, 1);
          if (exp_len.size() > 0) check("rx_q", rx_q, exp_len.pop_front());
          rx_q = 0;
        end
      end else begin
        check("a_idle", a, 0);
      end
      if (len_err) err_seen++;
      prev_valid = a_valid;
    end
  end

  task automatic send(input int len, output int stalls);
    in_valid = 1'b1;
    in_len   = 3'(len);
    stalls   = 0;
    while (1) begin
      @(negedge clk);
      if (in_ready) break;
      stalls++;
      if (stalls > 200) begin
        check("ready_timeout", stalls, 0);
        break;
      end
    end
    if (len <= MAXR) begin
      for (int i = 0; i < len; i++) exp_bits.push_back(1);
      exp_bits.push_back(0);
      exp_len.push_back(len);
    end else begin
      illegal_cnt++;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    $display("send L=%0d stalls=%0d", len, stalls);
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    do begin
      @(negedge clk);
      cycles++;
    end while (busy && cycles < 500);
    check("idle_timeout", busy, 0);
    check("drain", exp_bits.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int st, cyc, err0;
    int st6[6];
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_len   = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_a", a, 0);
    check("rst_a_valid", a_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_len_err", len_err, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    idle(2);

    // 1: single L=3, latency and busy fall
    send(3, st);
    @(negedge clk);
    check("t1_lat_c1", a_valid, 0);
    @(negedge clk);
    check("t1_lat_c2", a_valid, 1);
    wait_idle(cyc);
    check("t1_busy_fall", cyc, 4);

    // 2: 0,4,2 back-to-back, continuous a_valid
    vcount = 0; vrise = 0;
    send(0, st); send(4, st); send(2, st);
    wait_idle(cyc);
    check("t2_vcount", vcount, 9);
    check("t2_segments", vrise, 1);

    // 3: illegal 6 between 1 and 2
    vcount = 0; vrise = 0; err0 = err_seen;
    send(1, st); send(6, st); send(2, st);
    wait_idle(cyc);
    check("t3_len_err", err_seen - err0, 1);
    check("t3_vcount", vcount, 5);
    check("t3_segments", vrise, 1);

    // 4: six L=4 with no gaps, buffer fills
    vcount = 0;
    for (int i = 0; i < 6; i++) send(4, st6[i]);
    check("t4_stall_5th", st6[4], 0);
    check("t4_stall_6th", st6[5], 2);
    wait_idle(cyc);
    check("t4_vcount", vcount, 30);

    // 5: reset after two ones of L=4
    send(4, st);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    mon_en = 1'b0;
    check("t5_ones_before_rst", rx_q, 2);
    check("t5_a", a, 0);
    check("t5_a_valid", a_valid, 0);
    check("t5_busy", busy, 0);
    check("t5_in_ready", in_ready, 1);
    exp_bits.delete();
    exp_len.delete();
    rx_q       = 0;
    prev_valid = 1'b0;
    rst_n      = 1'b1;
    mon_en     = 1'b1;
    vcount     = 0;
    send(1, st);
    wait_idle(cyc);
    check("t5_after_vcount", vcount, 2);

    // 6: random lengths and gaps
    err0 = err_seen;
    illegal_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      int gap;
      gap = $urandom_range(0, 3);
      if (gap != 0) idle(gap);
      send($urandom_range(0, 7), st);
    end
    wait_idle(cyc);
    check("t6_len_err_count", err_seen - err0, illegal_cnt);
    check("t6_sym_drain", exp_len.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
